// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if -- operation/result bundle between the core control path
// and alu_multicycle.
//   master: drives start, ALUControl, SrcA, SrcB; observes the result side.
//   slave : the ALU; drives ready, busy, done, ALUResult, zero, overflow,
//           div_zero.
interface alu_multicycle_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALUControl_WIDTH = 4
);
  logic                        start;
  logic [ALUControl_WIDTH-1:0] ALUControl;
  logic [DATA_WIDTH-1:0]       SrcA;
  logic [DATA_WIDTH-1:0]       SrcB;
  logic                        ready;
  logic                        busy;
  logic                        done;
  logic [DATA_WIDTH-1:0]       ALUResult;
  logic                        zero;
  logic                        overflow;
  logic                        div_zero;

  modport master (
    output start, ALUControl, SrcA, SrcB,
    input  ready, busy, done, ALUResult, zero, overflow, div_zero
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB,
    output ready, busy, done, ALUResult, zero, overflow, div_zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle -- registered ALU for the multi-cycle MIPS core.
// Single-cycle ops (AND/OR/ADD/XOR/NOR/SLL/SUB/SLT/SRL/SRA, MFHI/MFLO) produce
// a result one edge after acceptance. MULT/MULTU/DIV/DIVU run an iterative
// one-bit-per-cycle shift-add / restoring-divide on operand magnitudes and
// write HI/LO after a final sign-correction cycle.
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_multicycle_if.slave (start/ALUControl/SrcA/SrcB in;
//           ready/busy/done/ALUResult/zero/overflow/div_zero out)
// Build option: define ALU_MULDIV_EN to include HI/LO and the multiply/divide
// engine; without it opcodes 10-15 are illegal and busy/div_zero are 0.
module alu_multicycle #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALUControl_WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  alu_multicycle_if.slave bus
);

  localparam int SH_W = $clog2(DATA_WIDTH);
  localparam int MSB  = DATA_WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'd0,  OP_OR    = 4'd1,  OP_ADD  = 4'd2,
                         OP_XOR  = 4'd3,  OP_NOR   = 4'd4,  OP_SLL  = 4'd5,
                         OP_SUB  = 4'd6,  OP_SLT   = 4'd7,  OP_SRL  = 4'd8,
                         OP_SRA  = 4'd9,  OP_MULT  = 4'd10, OP_MULTU = 4'd11,
                         OP_DIV  = 4'd12, OP_DIVU  = 4'd13, OP_MFHI = 4'd14,
                         OP_MFLO = 4'd15;

  logic                  legal;
  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] a, b, sum, diff, single_res;
  logic [SH_W-1:0]       shamt;
  logic                  single_ovf;

  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

  // Opcode bits above [3] must be zero for the opcode to be legal.
  generate
    if (ALUControl_WIDTH > 4) begin : g_wide_op
      assign legal = (bus.ALUControl[ALUControl_WIDTH-1:4] == '0);
    end else begin : g_narrow_op
      assign legal = 1'b1;
    end
  endgenerate

  assign op    = bus.ALUControl[3:0];
  assign a     = bus.SrcA;
  assign b     = bus.SrcB;
  assign shamt = b[SH_W-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

`ifdef ALU_MULDIV_EN
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
`endif

  always_comb begin : single_cycle
    single_res = '0;
    single_ovf = 1'b0;
    if (legal) begin
      case (op)
        OP_AND: single_res = a & b;
        OP_OR:  single_res = a | b;
        OP_ADD: begin
          single_res = sum;
          single_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        end
        OP_XOR: single_res = a ^ b;
        OP_NOR: single_res = ~(a | b);
        OP_SLL: single_res = a << shamt;
        OP_SUB: begin
          single_res = diff;
          single_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        end
        OP_SLT: single_res = {{MSB{1'b0}}, ($signed(a) < $signed(b))};
        OP_SRL: single_res = a >> shamt;
        OP_SRA: single_res = $signed(a) >>> shamt;
`ifdef ALU_MULDIV_EN
        OP_MFHI: single_res = hi_q;
        OP_MFLO: single_res = lo_q;
`endif
        default: single_res = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.ALUResult = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.done      = done_q;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [SH_W-1:0]         cnt_q, cnt_d;
  // acc: product high half / partial remainder; mq: multiplier / quotient;
  // dvs: multiplicand / divisor magnitude.
  logic [DATA_WIDTH-1:0]   acc_q, acc_d, mq_q, mq_d, dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0]   a_orig_q, a_orig_d;
  logic                    is_div_q, is_div_d, neg_q, neg_d;
  logic                    neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic                    is_long, a_neg, b_neg;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
  logic [DATA_WIDTH:0]     mul_add, rem_sh, trial;
  logic [2*DATA_WIDTH-1:0] prod, prod_fix;

  assign is_long = legal && (op == OP_MULT || op == OP_MULTU ||
                             op == OP_DIV  || op == OP_DIVU);
  // Signed variants (MULT, DIV) have op[0] = 0.
  assign a_neg = ~op[0] & a[MSB];
  assign b_neg = ~op[0] & b[MSB];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign mul_add  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dvs_q} : {(DATA_WIDTH+1){1'b0}});
  assign rem_sh   = {acc_q, mq_q[MSB]};
  // Remainder stays below the divisor, so bit DATA_WIDTH of trial is a borrow.
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign prod     = {acc_q, mq_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot_fix = neg_q ? -mq_q : mq_q;
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  always_comb begin : fsm_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    dvs_d     = dvs_q;
    a_orig_d  = a_orig_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_long) begin
            state_d   = RUN;
            cnt_d     = '0;
            acc_d     = '0;
            mq_d      = a_mag;
            dvs_d     = b_mag;
            a_orig_d  = a;
            is_div_d  = op[2];
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            ovf_d    = single_ovf;
            dz_d     = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!trial[DATA_WIDTH]) begin
            acc_d = trial[DATA_WIDTH-1:0];
            mq_d  = {mq_q[MSB-1:0], 1'b1};
          end else begin
            acc_d = rem_sh[DATA_WIDTH-1:0];
            mq_d  = {mq_q[MSB-1:0], 1'b0};
          end
        end else begin
          acc_d = mul_add[DATA_WIDTH:1];
          mq_d  = {mul_add[0], mq_q[MSB:1]};
        end
        cnt_d = cnt_q + SH_W'(1);
        if (cnt_q == SH_W'(DATA_WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_q && dvs_q == '0) begin
          lo_d = '1;
          hi_d = a_orig_q;
          dz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
          dz_d = 1'b0;
        end else begin
          lo_d = prod_fix[DATA_WIDTH-1:0];
          hi_d = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
          dz_d = 1'b0;
        end
        result_d = lo_d;
        zero_d   = (lo_d == '0);
        ovf_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      dvs_q     <= '0;
      a_orig_q  <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      dvs_q     <= dvs_d;
      a_orig_q  <= a_orig_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.div_zero = dz_q;
`else
  always_comb begin : accept_next
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (bus.start) begin
      result_d = single_res;
      zero_d   = (single_res == '0);
      ovf_d    = single_ovf;
      done_d   = 1'b1;
    end
  end

  assign bus.ready    = 1'b1;
  assign bus.busy     = 1'b0;
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle -- directed vectors against a behavioural model of
// alu_multicycle (DATA_WIDTH 32). A compare process checks done/busy/ready
// and the held result/flags every cycle outside reset.
module tb_alu_multicycle;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2,
                         OP_XOR = 4'd3, OP_NOR = 4'd4, OP_SLL = 4'd5,
                         OP_SUB = 4'd6, OP_SLT = 4'd7, OP_SRL = 4'd8,
                         OP_SRA = 4'd9, OP_MULT = 4'd10, OP_MULTU = 4'd11,
                         OP_DIV = 4'd12, OP_DIVU = 4'd13, OP_MFHI = 4'd14,
                         OP_MFLO = 4'd15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_multicycle_if #(.DATA_WIDTH(W), .ALUControl_WIDTH(4)) bus ();

  alu_multicycle #(.DATA_WIDTH(W), .ALUControl_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int long_due = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        dz;
    bit          has_lit;
    logic [31:0] lit;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] held_res = '0;
  logic        held_ovf = 1'b0, held_dz = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Expected result straight from the operation definitions; off is the
  // number of edges after acceptance before the done cycle begins.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ovf, output logic dz,
                                output int off);
    longint      sa, sb, s;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0; ovf = 1'b0; dz = 1'b0; off = 0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin res = a + b; s = sa + sb; ovf = (s > SMAX) || (s < SMIN); end
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_SLL: res = a << b[4:0];
      OP_SUB: begin res = a - b; s = sa - sb; ovf = (s > SMAX) || (s < SMIN); end
      OP_SLT: res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SRL: res = a >> b[4:0];
      OP_SRA: res = $signed(a) >>> b[4:0];
`ifdef ALU_MULDIV_EN
      OP_MULT: begin
        p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; off = W + 1;
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; off = W + 1;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          m_lo = '1; m_hi = a; dz = 1'b1;
        end else if (op == OP_DIV) begin
          q = 64'(sa / sb); r = 64'(sa % sb); m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        res = m_lo; off = W + 1;
      end
      OP_MFHI: res = m_hi;
      OP_MFLO: res = m_lo;
`endif
      default: res = '0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit has_lit, input logic [31:0] lit);
    exp_t e;
    int   off;
    bus.start = 1'b1; bus.ALUControl = op; bus.SrcA = a; bus.SrcB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.SrcA = $urandom;
    bus.SrcB = $urandom;
    model(op, a, b, e.res, e.ovf, e.dz, off);
    e.due = cyc + off; e.op = op; e.a = a; e.b = b; e.has_lit = has_lit; e.lit = lit;
    if (off > 0) long_due = e.due;
    expq.push_back(e);
  endtask

  task automatic issue_ignored(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.ALUControl = op; bus.SrcA = a; bus.SrcB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (long_due > cyc && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_result"}, bus.ALUResult, 32'd0);
    chk1({tag, "_zero"}, bus.zero, 1'b1);
    chk1({tag, "_done"}, bus.done, 1'b0);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_ready"}, bus.ready, 1'b1);
    chk1({tag, "_overflow"}, bus.overflow, 1'b0);
    chk1({tag, "_div_zero"}, bus.div_zero, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   exp_done;
    bit   exp_busy;
    if (rst_n) begin
      while (expq.size() > 0 && expq[0].due < cyc) begin
        e = expq.pop_front();
        $display("FAIL done_timeout: op %0d got no done expected done at cycle %0d", e.op, e.due);
        checks++;
      end
      exp_done = (expq.size() > 0) && (expq[0].due == cyc);
      exp_busy = (long_due > cyc);
      chk1("done", bus.done, exp_done);
      chk1("busy", bus.busy, exp_busy);
      chk1("ready", bus.ready, !exp_busy);
      if (exp_done) begin
        e = expq.pop_front();
        held_res = e.res; held_ovf = e.ovf; held_dz = e.dz;
        $display("txn op=%0d a=%h b=%h result=%h ovf=%b dz=%b", e.op, e.a, e.b,
                 bus.ALUResult, bus.overflow, bus.div_zero);
        if (e.has_lit) chk($sformatf("literal_op%0d", e.op), bus.ALUResult, e.lit);
      end
      chk("result", bus.ALUResult, held_res);
      chk1("zero", bus.zero, held_res == 32'd0);
      chk1("overflow", bus.overflow, held_ovf);
      chk1("div_zero", bus.div_zero, held_dz);
    end
  end

  initial begin
    bus.start = 1'b0; bus.ALUControl = '0; bus.SrcA = '0; bus.SrcB = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops.
    issue(OP_ADD, 32'd100, 32'd50, 1, 32'd150);
    issue(OP_SUB, 32'd100, 32'd100, 1, 32'd0);
    issue(OP_ADD, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000);
    issue(OP_SLT, 32'd50, 32'd70, 1, 32'd1);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1, 32'd1);
    issue(OP_SRA, 32'h8000_0000, 32'd4, 1, 32'hF800_0000);
    issue(OP_SLL, 32'd1, 32'd31, 1, 32'h8000_0000);
    issue(OP_SUB, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF);
    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 32'h00F0_1234);
    issue(OP_OR,  32'hF000_0000, 32'h0000_000F, 1, 32'hF000_000F);
    issue(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'hF0F0_0F0F);
    issue(OP_NOR, 32'd0, 32'd0, 1, 32'hFFFF_FFFF);
    issue(OP_SRL, 32'h8000_0000, 32'd36, 1, 32'h0800_0000);
    @(posedge clk); #1;

`ifdef ALU_MULDIV_EN
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFEB);
    wait_ready();
    issue(OP_MFHI, 32'd0, 32'd0, 1, 32'hFFFF_FFFF);
    issue(OP_MFLO, 32'd0, 32'd0, 1, 32'hFFFF_FFEB);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFE);
    wait_ready();
    issue(OP_MFHI, 32'd0, 32'd0, 1, 32'd1);
    issue(OP_DIVU, 32'd100, 32'd7, 1, 32'd14);
    wait_ready();
    issue(OP_MFHI, 32'd0, 32'd0, 1, 32'd2);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD);
    wait_ready();
    issue(OP_MFHI, 32'd0, 32'd0, 1, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    wait_ready();
    issue(OP_MFHI, 32'd0, 32'd0, 1, 32'd5);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    wait_ready();
    issue(OP_MFHI, 32'd0, 32'd0, 1, 32'd0);

    // A start during a divide must be dropped.
    issue(OP_DIV, 32'd1000, 32'd3, 1, 32'd333);
    repeat (4) @(posedge clk);
    #1 issue_ignored(OP_ADD, 32'd1, 32'd1);
    wait_ready();
    issue(OP_MFHI, 32'd0, 32'd0, 1, 32'd1);

    // Reset in the middle of a multiply.
    issue(OP_MULT, 32'd1234, 32'd5678, 0, 32'd0);
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    expq.delete();
    long_due = 0; m_hi = '0; m_lo = '0;
    held_res = '0; held_ovf = 1'b0; held_dz = 1'b0;
    #1 chk_reset_outputs("midop_reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(OP_MFHI, 32'd0, 32'd0, 1, 32'd0);
`else
    issue(OP_MULT, 32'd3, 32'd4, 1, 32'd0);
    issue(OP_MFLO, 32'd0, 32'd0, 1, 32'd0);
    issue(OP_ADD, 32'd3, 32'd4, 1, 32'd7);
`endif

    repeat (40) @(posedge clk);
    #1 chk1("queue_drained", expq.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised successor to the datapath ALU for the multi-cycle MIPS core. Accepts one operation per `start` handshake and registers the result. Adds the following over the combinational ALU:
- shifts, XOR/NOR and signed overflow detection;
- iterative MULT/MULTU/DIV/DIVU writing internal HI/LO registers, plus MFHI/MFLO.

Sits between the register-file read latches and the ALUOut register; the control FSM stalls on `busy`.

## Interface
- `DATA_WIDTH`, 32, operand/result width; power of two, ≥8
- `ALUControl_WIDTH`, 4, opcode width; ≥4, bits above [3] must be 0, else opcode is illegal
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  launch request; accepted only when `ready`=1
- `ALUControl`  in  ALUControl_WIDTH  opcode, sampled with `start`
- `SrcA`  in  DATA_WIDTH  operand A, sampled with `start`
- `SrcB`  in  DATA_WIDTH  operand B, sampled with `start`
- `ready`  out  1  idle, can accept `start`
- `busy`  out  1  multiply/divide in progress
- `done`  out  1  one-cycle pulse, `ALUResult`/flags valid
- `ALUResult`  out  DATA_WIDTH  registered result, held until next `done`
- `zero`  out  1  `ALUResult`==0, registered with it
- `overflow`  out  1  signed overflow on ADD/SUB, else 0
- `div_zero`  out  1  DIV/DIVU with `SrcB`==0

## Operation
Opcodes:
- Legacy codes are preserved: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed).
- New codes: 3 XOR, 4 NOR, 5 SLL, 8 SRL, 9 SRA, 10 MULT, 11 MULTU, 12 DIV, 13 DIVU, 14 MFHI, 15 MFLO.

Operation semantics:
- Shifts: `SrcA` is shifted by `SrcB[log2(DATA_WIDTH)-1:0]`.
- ADD/SUB wrap modulo 2^DATA_WIDTH. `overflow` = signed overflow.
- MULT/MULTU: {HI,LO} = full 2·DATA_WIDTH product, signed or unsigned. `ALUResult` = LO.
- DIV/DIVU: LO = quotient, HI = remainder, truncating toward zero (remainder takes the dividend's sign). `ALUResult` = LO.
- Divide by zero: LO = all ones, HI = `SrcA`, `div_zero`=1.
- Signed MIN/−1: LO = MIN, HI = 0.
- Illegal opcode: result 0, one-cycle latency, HI/LO unchanged.

State machine (state encoded IDLE/RUN/FIX):
- IDLE: `ready`=1. On `start` with a single-cycle op (including MFHI/MFLO): register result, pulse `done`, stay in IDLE. On `start` with MULT/MULTU/DIV/DIVU: latch operand magnitudes and signs, clear the counter, go to RUN.
- RUN: shift-add multiply or restoring divide, one bit per cycle, counter 0..DATA_WIDTH-1. Go to FIX after DATA_WIDTH cycles.
- FIX: apply two's-complement sign correction, write HI/LO and `ALUResult`, pulse `done`, return to IDLE.

Handshake and reset:
- `start` while `ready`=0 is ignored; no queueing.
- Operands may change freely after acceptance.
- `rst_n` low at any time, including mid-RUN: state → IDLE, counter/HI/LO/`ALUResult` = 0, `zero`=1, `done`=`busy`=`overflow`=`div_zero`=0, `ready`=1. The aborted operation is lost.

## Timing
- Acceptance edge = edge 0.
- Single-cycle ops: `done`=1 and result valid in the cycle following edge 0 (latency 1). Back-to-back `start` every cycle sustains full throughput.
- Multiply/divide: `busy`=1 from edge 0 through edge DATA_WIDTH+1. `done`=1 following edge DATA_WIDTH+1 (latency DATA_WIDTH+1; 33 for width 32). `ready` returns in the same cycle as `done`, so a new `start` is accepted there.
- MFHI/MFLO issued in the `done` cycle of a multiply/divide returns the new HI/LO.
- `done` is never high for two consecutive cycles for a multi-cycle op.
- `ALUResult` and flags change only at a `done` edge or at reset.

## Configuration
- `ALU_MULDIV_EN` defined: RUN/FIX states, HI/LO and the iterative datapath are compiled in as described.
- `ALU_MULDIV_EN` undefined: opcodes 10–15 are treated as illegal (result 0, latency 1). HI/LO are absent, `busy` is tied to 0, `div_zero` is tied to 0, and `ready` is tied to 1 out of reset.

## Test plan
- ADD 100+50, then SUB 100−100, back-to-back: `done` each cycle, ALUResult 150 then 0 with `zero`=1. ADD 0x7FFFFFFF+1 → 0x80000000, `overflow`=1.
- SLT 50,70 → 1; SLT 0xFFFFFFFF,1 → 1; SRA 0x80000000 by 4 → 0xF8000000; SLL 1 by 31 → 0x80000000.
- MULT −3×7: `done` 33 cycles after acceptance. MFHI → 0xFFFFFFFF, MFLO → 0xFFFFFFEB. MULTU 0xFFFFFFFF×2: HI=1, LO=0xFFFFFFFE.
- DIVU 100/7 → LO=14, HI=2. DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 5/0 → LO=0xFFFFFFFF, HI=5, `div_zero`=1.
- Mid-operation: `start` ADD at cycle 5 of a DIV is ignored (no extra `done`). Deassert `rst_n` at cycle 10 of a MULT: all outputs reach reset values immediately, `ready`=1, MFHI then returns 0.
- Build without `ALU_MULDIV_EN`: MULT 3×4 → result 0, `done` after 1 cycle, `busy` never 1.
